// File: rtl/register_file_32x32.sv
// register_file_32x32
// 32 x 32-bit register file: two combinational read ports, one write port.
// Register 0 reads as zero and is never stored. A write presented in the
// same cycle as a read of the same address is forwarded to the read port.
// A saturating count of committed writes is kept for debug visibility.

module register_file_32x32 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_addr_1,
    input  logic [ADDR_WIDTH-1:0] read_addr_2,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    output logic [7:0]            write_count
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    // Entry 0 is hardwired to zero, so storage starts at index 1.
    logic [DATA_WIDTH-1:0] r_mem [1:Depth-1];
    logic [7:0]            r_write_count;

    logic                  w_commit;
    logic                  w_bypass_1;
    logic                  w_bypass_2;
    logic [DATA_WIDTH-1:0] w_stored_1;
    logic [DATA_WIDTH-1:0] w_stored_2;

    // A write only commits outside reset and never to register 0.
    assign w_commit   = !reset && write_enable && (write_addr != '0);

    // Forwarding is suppressed during reset so reads show the pre-clear contents.
    assign w_bypass_1 = !reset && write_enable && (write_addr == read_addr_1);
    assign w_bypass_2 = !reset && write_enable && (write_addr == read_addr_2);

    // Storage update: reset clears every entry, otherwise the addressed entry takes the write.
    always_ff @(posedge clk) begin
        for (int i = 1; i < Depth; i++) begin
            if (reset) begin
                r_mem[i] <= '0;
            end else if (w_commit && (write_addr == ADDR_WIDTH'(i))) begin
                r_mem[i] <= write_data;
            end
        end
    end

    // Committed-write counter, saturating at its maximum value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write_count <= '0;
        end else if (w_commit && (r_write_count != 8'hFF)) begin
            r_write_count <= r_write_count + 8'd1;
        end
    end

    // Stored-value select for port 1; address 0 falls through to zero.
    always_comb begin
        w_stored_1 = '0;
        for (int i = 1; i < Depth; i++) begin
            if (read_addr_1 == ADDR_WIDTH'(i)) begin
                w_stored_1 = r_mem[i];
            end
        end
    end

    // Stored-value select for port 2; address 0 falls through to zero.
    always_comb begin
        w_stored_2 = '0;
        for (int i = 1; i < Depth; i++) begin
            if (read_addr_2 == ADDR_WIDTH'(i)) begin
                w_stored_2 = r_mem[i];
            end
        end
    end

    // Output select: zero register first, then forwarded write, then stored value.
    always_comb begin
        if (read_addr_1 == '0) begin
            read_data_1 = '0;
        end else if (w_bypass_1) begin
            read_data_1 = write_data;
        end else begin
            read_data_1 = w_stored_1;
        end

        if (read_addr_2 == '0) begin
            read_data_2 = '0;
        end else if (w_bypass_2) begin
            read_data_2 = write_data;
        end else begin
            read_data_2 = w_stored_2;
        end
    end

    assign write_count = r_write_count;

endmodule

// File: tb/tb_register_file_32x32.sv
// tb_register_file_32x32
// Directed vector table, reset/saturation sequences and randomized traffic
// checked against a simple array-based reference model.

module tb_register_file_32x32;

    logic        clk;
    logic        reset;
    logic [4:0]  read_addr_1;
    logic [4:0]  read_addr_2;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [7:0]  write_count;

    int tests;
    int fails;

    // Reference model state: register contents and committed-write count.
    logic [31:0] m_regs [0:31];
    int          m_count;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [7:0]  expcnt;
    } vec_t;

    vec_t vecs [10];

    register_file_32x32 #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .read_addr_1 (read_addr_1),
        .read_addr_2 (read_addr_2),
        .write_enable(write_enable),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2),
        .write_count (write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
        reset        = rst;
        write_enable = we;
        write_addr   = wa;
        write_data   = wd;
        read_addr_1  = ra1;
        read_addr_2  = ra2;
        #1;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (!reset && write_enable && write_addr == a) return write_data;
        return m_regs[a];
    endfunction

    // Advance one clock edge and apply the same edge to the model.
    task automatic edge_step();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_count = 0;
        end else if (write_enable && write_addr != 5'd0) begin
            m_regs[write_addr] = write_data;
            if (m_count < 255) m_count++;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_rd1"}, read_data_1, model_read(read_addr_1));
        check({tag, "_rd2"}, read_data_2, model_read(read_addr_2));
        check({tag, "_cnt"}, {24'h0, write_count}, 32'(m_count));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        m_count = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;

        // rst we wa wd ra1 ra2 exp1 exp2 cnt (expected before the edge)
        vecs[0] = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 8'd0};
        vecs[1] = '{1'b0, 1'b0, 5'd0, 32'h0,       5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 8'd1};
        vecs[2] = '{1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5, 32'h0,       32'hDEADBEEF, 8'd1};
        vecs[3] = '{1'b0, 1'b0, 5'd0, 32'h0,       5'd0, 5'd0, 32'h0,        32'h0,        8'd1};
        vecs[4] = '{1'b0, 1'b1, 5'd9, 32'h11111111, 5'd9, 5'd8, 32'h11111111, 32'h0,       8'd1};
        vecs[5] = '{1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 5'd8, 5'd9, 32'h0,       32'hCAFEF00D, 8'd2};
        vecs[6] = '{1'b0, 1'b0, 5'd0, 32'h0,       5'd9, 5'd9, 32'hCAFEF00D, 32'hCAFEF00D, 8'd3};
        vecs[7] = '{1'b0, 1'b1, 5'd3, 32'hAAAAAAAA, 5'd3, 5'd5, 32'hAAAAAAAA, 32'hDEADBEEF, 8'd3};
        vecs[8] = '{1'b1, 1'b1, 5'd3, 32'h55555555, 5'd3, 5'd5, 32'hAAAAAAAA, 32'hDEADBEEF, 8'd4};
        vecs[9] = '{1'b0, 1'b0, 5'd0, 32'h0,       5'd3, 5'd5, 32'h0,        32'h0,        8'd0};

        // Initial reset, then every address on both ports must read zero.
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        edge_step();
        drive(1'b1, 1'b1, 5'd7, 32'hFFFFFFFF, 5'd0, 5'd0);
        edge_step();
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
            check("reset_rd1", read_data_1, 32'h0);
            check("reset_rd2", read_data_2, 32'h0);
        end
        check("reset_cnt", {24'h0, write_count}, 32'h0);

        // Directed vector table.
        for (int v = 0; v < 10; v++) begin
            drive(vecs[v].rst, vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra1, vecs[v].ra2);
            check($sformatf("vec%0d_rd1", v), read_data_1, vecs[v].exp1);
            check($sformatf("vec%0d_rd2", v), read_data_2, vecs[v].exp2);
            check($sformatf("vec%0d_cnt", v), {24'h0, write_count}, {24'h0, vecs[v].expcnt});
            edge_step();
        end

        // Walk all writable registers, then keep writing until the count saturates.
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        edge_step();
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
            edge_step();
        end
        check("walk_cnt31", {24'h0, write_count}, 32'd31);
        for (int k = 0; k < 230; k++) begin
            logic [4:0] a;
            a = 5'(1 + (k % 31));
            drive(1'b0, 1'b1, a, 32'(a) * 32'h01010101, 5'd0, 5'd0);
            if (k == 223) check("cnt_254", {24'h0, write_count}, 32'd254);
            if (k == 224) check("cnt_255", {24'h0, write_count}, 32'd255);
            edge_step();
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        check("cnt_sat", {24'h0, write_count}, 32'd255);
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i));
            check("walk_rd1", read_data_1, 32'(i) * 32'h01010101);
            check("walk_rd2", read_data_2, 32'(i) * 32'h01010101);
        end

        // Randomized traffic against the reference model.
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        edge_step();
        for (int c = 0; c < 1500; c++) begin
            logic       rst;
            logic       we;
            logic [4:0] wa;
            logic [4:0] ra1;
            logic [4:0] ra2;
            rst = ($urandom_range(0, 63) == 0);
            we  = $urandom_range(0, 1) == 1;
            wa  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            drive(rst, we, wa, $urandom, ra1, ra2);
            check_model("rand");
            edge_step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
